// File: rtl/fir_pkg.sv
// Shared constants and elaboration helpers for the FIR datapath adders.
package fir_pkg;

    localparam int CSA_BLK_W = 2;

    // Each stage must hold a whole number of 2-bit carry-select blocks.
    function automatic bit csa_width_ok(input int data_width, input int stages);
        return (stages > 0) && ((data_width % (CSA_BLK_W * stages)) == 0);
    endfunction

endpackage

// File: rtl/csa_adder_block.sv
// 2-bit carry-select adder: both carry-in cases ripple in parallel, cin picks one.
module csa_adder_block (
    input  logic [1:0] in1,
    input  logic [1:0] in2,
    input  logic       cin,
    output logic [2:0] sum
);

    logic [2:0] sum0;
    logic [2:0] sum1;
    logic       c0_mid;
    logic       c1_mid;

    always_comb begin
        c0_mid  = in1[0] & in2[0];
        sum0[0] = in1[0] ^ in2[0];
        sum0[1] = in1[1] ^ in2[1] ^ c0_mid;
        sum0[2] = (in1[1] & in2[1]) | (c0_mid & (in1[1] ^ in2[1]));

        c1_mid  = in1[0] | in2[0];
        sum1[0] = ~(in1[0] ^ in2[0]);
        sum1[1] = in1[1] ^ in2[1] ^ c1_mid;
        sum1[2] = (in1[1] & in2[1]) | (c1_mid & (in1[1] ^ in2[1]));
    end

    mux_2X1 #(.W(3)) u_sel (
        .in0 (sum0),
        .in1 (sum1),
        .sel (cin),
        .out (sum)
    );

endmodule

// File: rtl/mux_2X1.sv
// Generic two-input multiplexer used by the carry-select blocks.
module mux_2X1 #(
    parameter int W = 3
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         sel,
    output logic [W-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/csa_adder_pipe.sv
// Pipelined unsigned adder: one carry-select slice per stage, carry registered
// between stages, operands skewed in and sums de-skewed out.
module csa_adder_pipe
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int STAGES     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   out_sum
);

    localparam int SLICE = DATA_WIDTH / STAGES;
    localparam int NBLK  = SLICE / CSA_BLK_W;

    if (!csa_width_ok(DATA_WIDTH, STAGES)) begin : g_bad_width
        $error("csa_adder_pipe: DATA_WIDTH must be a multiple of 2*STAGES");
    end

    logic                  advance;
    logic [STAGES-1:0]     v_q;
    logic [STAGES-1:0]     v_d;
    logic [STAGES-1:0]     carry_w;
    logic [DATA_WIDTH-1:0] sum_w;

    // A single global enable: the whole pipe moves or the whole pipe holds.
    assign advance   = !v_q[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[STAGES-1];
    assign out_sum   = {carry_w[STAGES-1], sum_w};

    always_comb begin
        v_d = v_q;
        if (advance) begin
            v_d[0] = in_valid;
            for (int i = 1; i < STAGES; i++) begin
                v_d[i] = v_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : stage_g
        localparam int DSK = STAGES - 1 - gi;

        logic [SLICE-1:0] a_op;
        logic [SLICE-1:0] b_op;
        logic             c_op;
        logic [SLICE-1:0] s_comb;
        logic [SLICE-1:0] s_q;
        logic [SLICE-1:0] s_d;
        logic             c_q;
        logic             c_d;

        if (gi == 0) begin : g_head
            assign a_op = in_a[SLICE-1:0];
            assign b_op = in_b[SLICE-1:0];
            assign c_op = in_cin;
        end else begin : g_skew
            logic [SLICE-1:0] a_sk_q [gi];
            logic [SLICE-1:0] a_sk_d [gi];
            logic [SLICE-1:0] b_sk_q [gi];
            logic [SLICE-1:0] b_sk_d [gi];

            always_comb begin
                for (int d = 0; d < gi; d++) begin
                    a_sk_d[d] = a_sk_q[d];
                    b_sk_d[d] = b_sk_q[d];
                end
                if (advance) begin
                    a_sk_d[0] = in_a[gi*SLICE +: SLICE];
                    b_sk_d[0] = in_b[gi*SLICE +: SLICE];
                    for (int d = 1; d < gi; d++) begin
                        a_sk_d[d] = a_sk_q[d-1];
                        b_sk_d[d] = b_sk_q[d-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d < gi; d++) begin
                        a_sk_q[d] <= '0;
                        b_sk_q[d] <= '0;
                    end
                end else begin
                    for (int d = 0; d < gi; d++) begin
                        a_sk_q[d] <= a_sk_d[d];
                        b_sk_q[d] <= b_sk_d[d];
                    end
                end
            end

            assign a_op = a_sk_q[gi-1];
            assign b_op = b_sk_q[gi-1];
            assign c_op = carry_w[gi-1];
        end

        for (genvar gj = 0; gj < NBLK; gj++) begin : blk_g
            logic       ci;
            logic       co;
            logic [2:0] blk_sum;

            if (gj == 0) begin : g_first
                assign ci = c_op;
            end else begin : g_chain
                assign ci = blk_g[gj-1].co;
            end

            csa_adder_block u_blk (
                .in1 (a_op[gj*CSA_BLK_W +: CSA_BLK_W]),
                .in2 (b_op[gj*CSA_BLK_W +: CSA_BLK_W]),
                .cin (ci),
                .sum (blk_sum)
            );

            assign s_comb[gj*CSA_BLK_W +: CSA_BLK_W] = blk_sum[1:0];
            assign co = blk_sum[2];
        end

        always_comb begin
            s_d = advance ? s_comb : s_q;
            c_d = advance ? blk_g[NBLK-1].co : c_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else begin
                s_q <= s_d;
                c_q <= c_d;
            end
        end

        assign carry_w[gi] = c_q;

        // Early slices wait here so every slice exits with the final carry.
        if (DSK == 0) begin : g_no_dsk
            assign sum_w[gi*SLICE +: SLICE] = s_q;
        end else begin : g_dsk
            logic [SLICE-1:0] dsk_q [DSK];
            logic [SLICE-1:0] dsk_d [DSK];

            always_comb begin
                for (int d = 0; d < DSK; d++) begin
                    dsk_d[d] = dsk_q[d];
                end
                if (advance) begin
                    dsk_d[0] = s_q;
                    for (int d = 1; d < DSK; d++) begin
                        dsk_d[d] = dsk_q[d-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d < DSK; d++) begin
                        dsk_q[d] <= '0;
                    end
                end else begin
                    for (int d = 0; d < DSK; d++) begin
                        dsk_q[d] <= dsk_d[d];
                    end
                end
            end

            assign sum_w[gi*SLICE +: SLICE] = dsk_q[DSK-1];
        end
    end

endmodule

// File: tb/tb_csa_adder_pipe.sv
// Scoreboard bench for csa_adder_pipe: expected sums queued on acceptance,
// compared on retirement, with directed latency/stall/bubble/reset checks.
module tb_csa_adder_pipe;

    localparam int DW = 16;
    localparam int ST = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [DW:0]   out_sum;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ret    = 0;
    logic [DW:0] sb [$];

    csa_adder_pipe #(.DATA_WIDTH(DW), .STAGES(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on retire.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    logic [DW:0] e;
                    e = sb.pop_front();
                    check_eq("sum", 32'(out_sum), 32'(e));
                    $display("retire #%0d sum=0x%05h exp=0x%05h", n_ret, out_sum, e);
                    n_ret++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({1'b0, in_a} + {1'b0, in_b} + {{DW{1'b0}}, in_cin});
            end
        end
    end

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("send_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        logic [31:0] r;
        r = $urandom;
        send(r[15:0], r[31:16], r[0] ^ r[17]);
    endtask

    initial begin
        logic [DW:0] held;
        logic [3:0]  pat;
        int          base;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_sum", 32'(out_sum), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single op, exact latency: visible after the 4th edge counting the accept edge.
        send(16'h1234, 16'h0001, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < ST + 1; i++) begin
            @(negedge clk);
            check_eq("single_latency_valid", 32'(out_valid), 32'(i == ST - 1));
            if (i == ST - 1) check_eq("single_sum", 32'(out_sum), 32'h01235);
        end

        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // 32 back-to-back: all must have retired one per cycle by e32+3.
        base = n_ret;
        for (int i = 0; i < 32; i++) send_rand();
        in_valid = 1'b0;
        repeat (ST - 1) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("stream_count", 32'(n_ret - base), 32'd32);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: 5-cycle stall once the pipe is full.
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand();
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                held = out_sum;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                    check_eq("stall_sum_stable", 32'(out_sum), 32'(held));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;

        // Bubbles: 1,0,1,0 in -> 1,0,1,0 out delayed by the pipe depth.
        pat = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] r;
            r        = $urandom;
            in_valid = pat[i];
            in_a     = r[15:0];
            in_b     = r[31:16];
            in_cin   = r[5];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("bubble_valid", 32'(out_valid), 32'(pat[i]));
        end
        repeat (4) @(posedge clk);
        #1;

        // Reset with ops in flight.
        for (int i = 0; i < 3; i++) send_rand();
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check_eq("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_out_sum", 32'(out_sum), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("postrst_in_ready", 32'(in_ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        base = n_ret;
        send(16'd5, 16'd7, 1'b0);
        in_valid = 1'b0;
        repeat (ST + 2) @(posedge clk);
        #1;
        check_eq("postrst_one_result", 32'(n_ret - base), 32'd1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
